// File: rtl/cpu_host_sequencer.sv
// Host sequencer for the CPU start/done protocol: preloads data memory from a byte stream,
// runs the CPU with a cycle limit, then streams a result window of data memory back out.
module cpu_host_sequencer #(
  parameter int unsigned AW        = 8,
  parameter int unsigned START_CYC = 2,
  parameter int unsigned MAX_CYC   = 4096,
  parameter int unsigned CW        = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          go_i,
  input  logic [AW-1:0] load_base_i,
  input  logic [AW-1:0] load_len_i,
  input  logic [AW-1:0] dump_base_i,
  input  logic [AW-1:0] dump_len_i,
  input  logic          in_valid_i,
  input  logic [7:0]    in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [7:0]    out_data_o,
  input  logic          out_ready_i,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_wdata_o,
  input  logic [7:0]    mem_rdata_i,
  output logic          host_owns_o,
  output logic          cpu_start_o,
  input  logic          cpu_done_i,
  output logic          busy_o,
  output logic          timeout_o,
  output logic [CW-1:0] cycles_o
);

  localparam int unsigned SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StRun,
    StTimeout,
    StDump
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] load_base_q, load_base_d;
  logic [AW-1:0] load_len_q, load_len_d;
  logic [AW-1:0] dump_base_q, dump_base_d;
  logic [AW-1:0] dump_len_q, dump_len_d;
  logic [AW-1:0] idx_q, idx_d, idx_inc;
  logic [CW-1:0] cycles_q, cycles_d, cycles_inc;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          timeout_q, timeout_d;
  logic          run_limit;
  logic          load_acc;

  logic in_ready_q, out_valid_q, host_owns_q, cpu_start_q, busy_q;

  assign idx_inc    = idx_q + AW'(1);
  assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CW'(1);
  assign run_limit  = 32'(cycles_inc) >= MAX_CYC;

  always_comb begin
    state_d     = state_q;
    load_base_d = load_base_q;
    load_len_d  = load_len_q;
    dump_base_d = dump_base_q;
    dump_len_d  = dump_len_q;
    idx_d       = idx_q;
    cycles_d    = cycles_q;
    scnt_d      = scnt_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (go_i) begin
          load_base_d = load_base_i;
          load_len_d  = load_len_i;
          dump_base_d = dump_base_i;
          dump_len_d  = dump_len_i;
          idx_d       = '0;
          cycles_d    = '0;
          scnt_d      = '0;
          timeout_d   = 1'b0;
          state_d     = (load_len_i == '0) ? StStart : StLoad;
        end
      end
      StLoad: begin
        if (in_valid_i) begin
          idx_d = idx_inc;
          if (idx_inc == load_len_q) begin
            scnt_d  = '0;
            state_d = StStart;
          end
        end
      end
      StStart: begin
        if (scnt_q == SW'(START_CYC - 1)) state_d = StRun;
        else scnt_d = scnt_q + SW'(1);
      end
      StRun: begin
        cycles_d = cycles_inc;
        // done takes priority over reaching the limit in the same cycle
        if (cpu_done_i) begin
          idx_d   = '0;
          state_d = (dump_len_q == '0) ? StIdle : StDump;
        end else if (run_limit) begin
          state_d = StTimeout;
        end
      end
      StTimeout: begin
        timeout_d = 1'b1;
        idx_d     = '0;
        state_d   = (dump_len_q == '0) ? StIdle : StDump;
      end
      StDump: begin
        if (out_ready_i) begin
          idx_d = idx_inc;
          if (idx_inc == dump_len_q) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      load_base_q <= '0;
      load_len_q  <= '0;
      dump_base_q <= '0;
      dump_len_q  <= '0;
      idx_q       <= '0;
      cycles_q    <= '0;
      scnt_q      <= '0;
      timeout_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      host_owns_q <= 1'b1;
      cpu_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_base_q <= load_base_d;
      load_len_q  <= load_len_d;
      dump_base_q <= dump_base_d;
      dump_len_q  <= dump_len_d;
      idx_q       <= idx_d;
      cycles_q    <= cycles_d;
      scnt_q      <= scnt_d;
      timeout_q   <= timeout_d;
      in_ready_q  <= (state_d == StLoad);
      out_valid_q <= (state_d == StDump);
      host_owns_q <= !((state_d == StStart) || (state_d == StRun));
      // TIMEOUT keeps start asserted so the CPU is held in its reset state
      cpu_start_q <= (state_d == StStart) || (state_d == StTimeout);
      busy_q      <= (state_d != StIdle);
    end
  end

  assign load_acc = (state_q == StLoad) && in_valid_i;

  always_comb begin
    mem_addr_o = '0;
    if (state_q == StLoad) mem_addr_o = load_base_q + idx_q;
    else if (state_q == StDump) mem_addr_o = dump_base_q + idx_q;
  end

  assign mem_we_o    = load_acc;
  assign mem_wdata_o = load_acc ? in_data_i : 8'h00;
  assign out_data_o  = out_valid_q ? mem_rdata_i : 8'h00;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign host_owns_o = host_owns_q;
  assign cpu_start_o = cpu_start_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;
  assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_cpu_host_sequencer.sv
// Self-checking bench for cpu_host_sequencer: cycle-predictive model of the load/start/run/dump
// sequence with a behavioural byte memory, directed corner cases and randomized runs.
module tb_cpu_host_sequencer;

  localparam int MAXC  = 16;
  localparam int STCYC = 2;

  logic        clk = 1'b0;
  logic        reset, go, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  load_base, load_len, dump_base, dump_len, in_data, out_data;
  logic        mem_we, host_owns, cpu_start, cpu_done, busy, timeout;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic [15:0] cycles;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  lbytes  [4];
  bit          use_lbytes;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cpu_host_sequencer #(
    .AW(8), .START_CYC(STCYC), .MAX_CYC(MAXC), .CW(16)
  ) dut (
    .clk_i(clk), .reset_i(reset), .go_i(go),
    .load_base_i(load_base), .load_len_i(load_len),
    .dump_base_i(dump_base), .dump_len_i(dump_len),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .host_owns_o(host_owns), .cpu_start_o(cpu_start), .cpu_done_i(cpu_done),
    .busy_o(busy), .timeout_o(timeout), .cycles_o(cycles)
  );

  // Data memory beside the DUT; the bench resets it to a known pattern together with the DUT
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'((i * 37 + 5) & 255);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'((i * 37 + 5) & 255);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full go..idle sequence. d = RUN cycle index at which cpu_done is raised.
  task automatic run_seq(input logic [7:0] lb, input logic [7:0] ll, input logic [7:0] db,
                         input logic [7:0] dl, input int d, input bit lrand, input bit rrand,
                         input logic [31:0] rpat, input bit go_in_run);
    int          k, j, cyc, r;
    bit          v, rdy, fin;
    logic [7:0]  b, a;
    logic [15:0] exp_cyc;
    bit          exp_to;
    exp_to  = (d + 1 > MAXC);
    exp_cyc = exp_to ? 16'(MAXC) : 16'(d + 1);

    @(negedge clk);
    go = 1'b1; load_base = lb; load_len = ll; dump_base = db; dump_len = dl;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_addr", mem_addr, 0);
    @(negedge clk);
    go = 1'b0;
    chk("go_clr_timeout", timeout, 0);
    chk("go_clr_cycles", cycles, 0);

    k = 0; cyc = 0;
    while (k < int'(ll) && cyc < 2000) begin
      v = lrand ? 1'($urandom_range(0, 1)) : 1'b1;
      b = use_lbytes ? lbytes[k % 4] : 8'($urandom);
      in_valid = v; in_data = b;
      #1;
      chk("load_in_ready", in_ready, 1);
      chk("load_host_owns", host_owns, 1);
      chk("load_we", mem_we, v);
      if (v) begin
        a = lb + 8'(k);
        chk("load_addr", mem_addr, a);
        chk("load_wdata", mem_wdata, b);
        ref_mem[a] = b;
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!lrand) chk("load_cycles", cyc, ll);

    for (int s = 0; s < STCYC; s++) begin
      cpu_done = 1'($urandom_range(0, 1));
      #1;
      chk("start_cpu_start", cpu_start, 1);
      chk("start_host_owns", host_owns, 0);
      chk("start_cycles", cycles, 0);
      chk("start_we", mem_we, 0);
      @(negedge clk);
    end

    r = 0; fin = 1'b0;
    while (!fin) begin
      cpu_done = (r == d);
      go = go_in_run && (r == 0);
      if (go) begin load_len = 8'd5; dump_len = 8'd5; end
      #1;
      chk("run_cpu_start", cpu_start, 0);
      chk("run_host_owns", host_owns, 0);
      chk("run_cycles", cycles, r);
      chk("run_we", mem_we, 0);
      if (r == d || r == MAXC - 1) fin = 1'b1;
      else r++;
      @(negedge clk);
    end
    cpu_done = 1'b0; go = 1'b0;

    if (exp_to) begin
      #1;
      chk("to_cpu_start", cpu_start, 1);
      chk("to_host_owns", host_owns, 1);
      chk("to_out_valid", out_valid, 0);
      chk("to_cycles", cycles, MAXC);
      @(negedge clk);
    end

    j = 0; cyc = 0;
    if (dl != 0) begin
      chk("dump_timeout", timeout, exp_to);
      chk("dump_cycles", cycles, exp_cyc);
    end
    while (j < int'(dl) && cyc < 2000) begin
      rdy = rrand ? 1'($urandom_range(0, 1)) : ((cyc < 32) ? rpat[cyc] : 1'b1);
      out_ready = rdy;
      #1;
      a = db + 8'(j);
      chk("dump_valid", out_valid, 1);
      chk("dump_host_owns", host_owns, 1);
      chk("dump_addr", mem_addr, a);
      chk("dump_data", out_data, ref_mem[a]);
      if (rdy) j++;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;

    #1;
    chk("end_busy", busy, 0);
    chk("end_out_valid", out_valid, 0);
    chk("end_host_owns", host_owns, 1);
    chk("end_cycles", cycles, exp_cyc);
    chk("end_timeout", timeout, exp_to);
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    cpu_done = 1'b0; load_base = 8'h00; load_len = 8'h00; dump_base = 8'h00; dump_len = 8'h00;
    use_lbytes = 1'b0;
    do_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cpu_start", cpu_start, 0);
    chk("rst_host_owns", host_owns, 1);
    chk("rst_timeout", timeout, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);

    // Back-to-back preload, done 5 cycles after start drops, wrapping dump with stalls
    lbytes[0] = 8'hA1; lbytes[1] = 8'hB2; lbytes[2] = 8'hC3; lbytes[3] = 8'h00;
    use_lbytes = 1'b1;
    run_seq(8'h10, 8'd3, 8'hFE, 8'd4, 5, 1'b0, 1'b0, 32'b101101, 1'b0);
    use_lbytes = 1'b0;
    run_seq(8'h0E, 8'd3, 8'h10, 8'd3, 0, 1'b0, 1'b1, 32'h0, 1'b0);

    // Timeout, then a skip-everything run that must clear it and ignore go during RUN
    run_seq(8'h30, 8'd2, 8'h2F, 8'd4, 1000, 1'b1, 1'b1, 32'h0, 1'b0);
    run_seq(8'h00, 8'd0, 8'h00, 8'd0, 2, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #1;
    chk("go_in_run_ignored", busy, 0);

    // Done on the limit cycle wins; timeout without dump
    run_seq(8'h40, 8'd1, 8'h40, 8'd1, MAXC - 1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    run_seq(8'h50, 8'd0, 8'h50, 8'd0, 1000, 1'b0, 1'b0, 32'h0, 1'b0);

    // Address wrap on load
    run_seq(8'hFD, 8'd5, 8'hFC, 8'd7, 3, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);

    for (int n = 0; n < 10; n++) begin
      run_seq(8'($urandom), 8'($urandom_range(0, 12)), 8'($urandom), 8'($urandom_range(0, 12)),
              int'($urandom_range(0, 20)), 1'b1, 1'b1, 32'h0, 1'b0);
    end

    // Reset during LOAD after one byte
    @(negedge clk);
    go = 1'b1; load_base = 8'h20; load_len = 8'd5; dump_base = 8'h20; dump_len = 8'd5;
    @(negedge clk);
    go = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    #1;
    chk("midrst_first_we", mem_we, 1);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'((i * 37 + 5) & 255);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_host_owns", host_owns, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_we", mem_we, 0);
    chk("midrst_addr", mem_addr, 0);
    @(negedge clk);
    #1;
    chk("midrst_we_later", mem_we, 0);
    in_valid = 1'b0;

    run_seq(8'h20, 8'd2, 8'h1F, 8'd4, 4, 1'b0, 1'b1, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
